segment_2x7_rx: RTL and testbench

//  Receive end of the 2-digit multiplexed 7-segment PMOD interface: watches active-low segment lines

---
 rtl/seg7_pkg.sv | 39 +++
 rtl/seg7_sync.sv | 38 +++
 rtl/segment_2x7_rx.sv | 148 ++++++++++++++
 tb/tb_segment_2x7_rx.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// ============================================================================
// Module : seg7_pkg
// Brief  : Shared 7-segment glyph table and encode/decode helpers for 2x7 PMOD
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

  localparam int SEG_W = 7;

  typedef enum logic {
    PH_SETTLE  = 1'b0,
    PH_SAMPLED = 1'b1
  } phase_e;

  // Active-low glyphs, bit order g..a; index is the hex nibble.
  localparam logic [15:0][SEG_W-1:0] SEG7_GLYPHS = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h18, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [SEG_W-1:0] seg7_encode(input logic [3:0] nib);
    return SEG7_GLYPHS[nib];
  endfunction

  // Returns {ok, nibble}; ok=0 for any pattern outside the table.
  function automatic logic [4:0] seg7_decode(input logic [SEG_W-1:0] pat);
    logic [4:0] res;
    res = 5'b0;
    for (int i = 0; i < 16; i++) begin
      if (SEG7_GLYPHS[i] == pat) res = {1'b1, 4'(i)};
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_sync.sv
// ============================================================================
// Module : seg7_sync
// Brief  : Parametrised multi-flop synchroniser for asynchronous inputs
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seg7_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stage_q[0] <= '0;
    else        stage_q[0] <= d_i;
  end

  generate
    for (genvar s = 1; s < DEPTH; s++) begin : g_stage
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stage_q[s] <= '0;
        else        stage_q[s] <= stage_q[s-1];
      end
    end
  endgenerate

  assign q_o = stage_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/segment_2x7_rx.sv
// ============================================================================
// Module : segment_2x7_rx
// Brief  : Receiver for 2-digit multiplexed 7-seg lines; recovers displayed byte
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module segment_2x7_rx
  import seg7_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEG_W-1:0] seg_in,
  input  logic             dig_sel,
  output logic [7:0]       number,
  output logic             number_valid,
  output logic             update,
  output logic             pattern_err
);

  localparam int SCNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [SCNT_W-1:0] SETTLE_LAST  = SCNT_W'(SETTLE_CYCLES - 1);
  localparam logic [TCNT_W-1:0] TIMEOUT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

  logic [SEG_W:0]   sync_s;
  logic [SEG_W-1:0] seg_s;
  logic             dig_s;

  seg7_sync #(
    .WIDTH (SEG_W + 1),
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   ({dig_sel, seg_in}),
    .q_o   (sync_s)
  );

  assign dig_s = sync_s[SEG_W];
  assign seg_s = sync_s[SEG_W-1:0];

  logic             dig_prev_q;
  logic [SEG_W-1:0] seg_prev_q;
  phase_e           state_q, state_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;
  logic [3:0]       low_q;
  logic             low_ok_q;
  logic [7:0]       number_q;
  logic             valid_q, update_q, perr_q;

  logic       dig_edge;
  logic       sample;
  logic       timeout;
  logic [4:0] dec;

  assign dig_edge = dig_s ^ dig_prev_q;
  assign timeout  = !dig_edge && (tcnt_q == TIMEOUT_LAST);
  assign dec      = seg7_decode(seg_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PH_SETTLE;
      scnt_q     <= '0;
      tcnt_q     <= '0;
      dig_prev_q <= 1'b0;
      seg_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      scnt_q     <= scnt_d;
      tcnt_q     <= tcnt_d;
      dig_prev_q <= dig_s;
      seg_prev_q <= seg_s;
    end
  end

  // A dig_sel edge restarts the phase and wins over a same-cycle sample.
  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    sample  = 1'b0;
    if (dig_edge) begin
      state_d = PH_SETTLE;
      scnt_d  = '0;
    end else if (state_q == PH_SETTLE) begin
      if (seg_s == seg_prev_q) begin
        if (scnt_q == SETTLE_LAST) begin
          sample  = 1'b1;
          state_d = PH_SAMPLED;
          scnt_d  = '0;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end else begin
        scnt_d = '0;
      end
    end
  end

  always_comb begin
    tcnt_d = tcnt_q;
    if (dig_edge)                  tcnt_d = '0;
    else if (tcnt_q != TIMEOUT_LAST) tcnt_d = tcnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      low_q    <= '0;
      low_ok_q <= 1'b0;
      number_q <= '0;
      valid_q  <= 1'b0;
      update_q <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      update_q <= 1'b0;
      perr_q   <= 1'b0;
      if (timeout) valid_q <= 1'b0;
      if (sample) begin
        if (!dec[4]) begin
          perr_q <= 1'b1;
          if (dig_s) low_ok_q <= 1'b0;
        end else if (dig_s) begin
          low_q    <= dec[3:0];
          low_ok_q <= 1'b1;
        end else if (low_ok_q) begin
          // High nibble closes the pair; commit pulses even for a repeated value.
          number_q <= {dec[3:0], low_q};
          update_q <= 1'b1;
          valid_q  <= 1'b1;
          low_ok_q <= 1'b0;
        end
      end
    end
  end

  assign number       = number_q;
  assign number_valid = valid_q;
  assign update       = update_q;
  assign pattern_err  = perr_q;

endmodule

`default_nettype wire

// File: tb/tb_segment_2x7_rx.sv
// ============================================================================
// Module : tb_segment_2x7_rx
// Brief  : Self-checking bench for segment_2x7_rx with commit scoreboard
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_segment_2x7_rx;
  import seg7_pkg::*;

  localparam int TIMEOUT = 1024;
  localparam logic [6:0] BLANK = 7'h7F;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg_in = 7'h40;
  logic       dig_sel = 1'b0;
  logic [7:0] number;
  logic       number_valid, update, pattern_err;

  segment_2x7_rx #(
    .SYNC_STAGES    (2),
    .SETTLE_CYCLES  (4),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .seg_in       (seg_in),
    .dig_sel      (dig_sel),
    .number       (number),
    .number_valid (number_valid),
    .update       (update),
    .pattern_err  (pattern_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int err_cnt  = 0;
  logic upd_prev = 1'b0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard: every update pulse must match the oldest pending commit.
  always @(negedge clk) begin
    if (rst_n) begin
      if (update) begin
        check("update_one_cycle", {31'b0, upd_prev}, 32'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_update: got number %0h expected no update", number);
        end else begin
          check("commit_number", {24'b0, number}, {24'b0, exp_q.pop_front()});
          check("commit_valid", {31'b0, number_valid}, 32'd1);
        end
      end
      if (pattern_err) err_cnt++;
    end
    upd_prev = update;
  end

  task automatic drive_phase(input logic d, input logic [6:0] s, input int n);
    @(negedge clk);
    dig_sel = d;
    seg_in  = s;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic check_state(input string tag, input logic [7:0] num, input logic vld);
    check({tag, "_number"}, {24'b0, number}, {24'b0, num});
    check({tag, "_valid"}, {31'b0, number_valid}, {31'b0, vld});
    check({tag, "_pending"}, exp_q.size(), 32'd0);
  endtask

  typedef struct {
    logic [6:0] lo_seg;
    logic [6:0] hi_seg;
    logic       commit;
    logic [7:0] exp_num;
    int         exp_errs;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int e0;
    vecs[0] = '{7'h08, 7'h30, 1'b1, 8'h3A, 0};
    vecs[1] = '{7'h46, 7'h21, 1'b1, 8'hDC, 0};
    vecs[2] = '{7'h79, BLANK, 1'b0, 8'hDC, 1};
    vecs[3] = '{BLANK, 7'h24, 1'b0, 8'hDC, 1};
    vecs[4] = '{7'h40, 7'h40, 1'b1, 8'h00, 0};
    vecs[5] = '{7'h0E, 7'h0E, 1'b1, 8'hFF, 0};
    vecs[6] = '{7'h78, BLANK, 1'b0, 8'hFF, 1};
    vecs[7] = '{7'h18, 7'h00, 1'b1, 8'h89, 0};

    repeat (3) @(negedge clk);
    check("rst_number", {24'b0, number}, 32'd0);
    check("rst_valid", {31'b0, number_valid}, 32'd0);
    check("rst_update", {31'b0, update}, 32'd0);
    check("rst_perr", {31'b0, pattern_err}, 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Blank low digit is an error, not zero; the following high alone cannot commit.
    e0 = err_cnt;
    drive_phase(1'b1, BLANK, 20);
    drive_phase(1'b0, seg7_encode(4'h5), 20);
    check("blank_errs", err_cnt - e0, 32'd1);
    check_state("blank", 8'h00, 1'b0);

    for (int i = 0; i < 8; i++) begin
      e0 = err_cnt;
      drive_phase(1'b1, vecs[i].lo_seg, 20);
      if (vecs[i].commit) exp_q.push_back(vecs[i].exp_num);
      drive_phase(1'b0, vecs[i].hi_seg, 20);
      check($sformatf("vec%0d_errs", i), err_cnt - e0, vecs[i].exp_errs);
      check_state($sformatf("vec%0d", i), vecs[i].exp_num, 1'b1);
    end

    // One-cycle glitch inside the high settle window must not be captured.
    drive_phase(1'b1, seg7_encode(4'h0), 20);
    exp_q.push_back(8'hF0);
    drive_phase(1'b0, seg7_encode(4'hF), 2);
    drive_phase(1'b0, 7'h00, 1);
    drive_phase(1'b0, seg7_encode(4'hF), 20);
    check_state("glitch", 8'hF0, 1'b1);

    // Link timeout drops valid but keeps the number; next pair revives it.
    drive_phase(1'b1, seg7_encode(4'hA), 20);
    exp_q.push_back(8'h3A);
    drive_phase(1'b0, seg7_encode(4'h3), 20);
    check_state("pre_timeout", 8'h3A, 1'b1);
    repeat (TIMEOUT + 5) @(negedge clk);
    check_state("timeout", 8'h3A, 1'b0);
    drive_phase(1'b1, seg7_encode(4'h7), 20);
    exp_q.push_back(8'h07);
    drive_phase(1'b0, seg7_encode(4'h0), 20);
    check_state("revive", 8'h07, 1'b1);

    // Reset after the low nibble was taken discards it.
    drive_phase(1'b1, seg7_encode(4'h9), 20);
    drive_phase(1'b0, seg7_encode(4'h2), 2);
    rst_n = 1'b0;
    #1;
    check("midrst_number", {24'b0, number}, 32'd0);
    check("midrst_valid", {31'b0, number_valid}, 32'd0);
    check("midrst_update", {31'b0, update}, 32'd0);
    check("midrst_perr", {31'b0, pattern_err}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_state("postrst_high_only", 8'h00, 1'b0);
    drive_phase(1'b1, seg7_encode(4'h4), 20);
    exp_q.push_back(8'h64);
    drive_phase(1'b0, seg7_encode(4'h6), 20);
    check_state("postrst_pair", 8'h64, 1'b1);

    // Loopback-style sweep using the shared encode table.
    e0 = err_cnt;
    for (int v = 0; v < 256; v++) begin
      logic [7:0] b;
      b = 8'(v);
      drive_phase(1'b1, seg7_encode(b[3:0]), 10);
      exp_q.push_back(b);
      drive_phase(1'b0, seg7_encode(b[7:4]), 10);
    end
    repeat (10) @(negedge clk);
    check("sweep_errs", err_cnt - e0, 32'd0);
    check_state("sweep", 8'hFF, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
